// File: rtl/dmem_store_responder_if.sv
// rtl/dmem_store_responder_if.sv - store/load port between the pipeline and the data memory responder
interface dmem_store_responder_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/dmem_store_responder.sv
// rtl/dmem_store_responder.sv - word RAM serving loads/stores plus a host-address pass/fail FSM
module dmem_store_responder #(
  parameter int          DEPTH_WORDS    = 64,
  parameter logic [31:0] HOST_ADDR      = 32'd100,
  parameter logic [31:0] PASS_VALUE     = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter bit          STRICT         = 1'b1,
  parameter int          TIMEOUT_CYCLES = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_store_responder_if.slave  bus,
  output logic                   done,
  output logic                   pass,
  output logic [2:0]             fail_code,
  output logic [15:0]            store_count,
  output logic [31:0]            last_adr,
  output logic [31:0]            last_data
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t      state_q, state_d;
  logic [2:0]  fail_code_q, fail_code_d;
  logic [15:0] store_count_q, store_count_d;
  logic [31:0] last_adr_q, last_adr_d;
  logic [31:0] last_data_q, last_data_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        mem_we;
  logic        word_in_range;
  logic [31:0] mem_q [DEPTH_WORDS];

  assign word_in_range = {2'b00, bus.DataAdr[31:2]} < 32'(DEPTH_WORDS);
  assign bus.ReadData  = mem_q[bus.DataAdr[2 +: AW]];

  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    store_count_d = store_count_q;
    last_adr_d    = last_adr_q;
    last_data_d   = last_data_q;
    cycle_cnt_d   = cycle_cnt_q;
    mem_we        = 1'b0;
    if (state_q == ST_RUN) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (cycle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d     = ST_FAIL;
        fail_code_d = 3'd4;
      end
      // Terminal stores are evaluated after the timeout so they override it.
      if (bus.MemWrite) begin
        last_adr_d  = bus.DataAdr;
        last_data_d = bus.WriteData;
        if (bus.DataAdr[1:0] != 2'b00) begin
          state_d     = ST_FAIL;
          fail_code_d = 3'd3;
        end else if (bus.DataAdr == HOST_ADDR) begin
          mem_we = word_in_range;
          if (bus.WriteData == PASS_VALUE) begin
            state_d     = ST_PASS;
            fail_code_d = 3'd0;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = 3'd2;
          end
        end else if (STRICT && (bus.DataAdr != SCRATCH_ADDR)) begin
          state_d     = ST_FAIL;
          fail_code_d = 3'd1;
        end else begin
          mem_we = word_in_range;
        end
      end
    end
    if (mem_we && (store_count_q != 16'hFFFF)) begin
      store_count_d = store_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fail_code_q   <= 3'd0;
      store_count_q <= 16'd0;
      last_adr_q    <= 32'd0;
      last_data_q   <= 32'd0;
      cycle_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      store_count_q <= store_count_d;
      last_adr_q    <= last_adr_d;
      last_data_q   <= last_data_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  // RAM survives reset; writes are only suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[bus.DataAdr[2 +: AW]] <= bus.WriteData;
    end
  end

  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail_code   = fail_code_q;
  assign store_count = store_count_q;
  assign last_adr    = last_adr_q;
  assign last_data   = last_data_q;
endmodule
